// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU memory-port control path.
package ctrl_pkg;

  localparam logic [1:0] IORD_PC  = 2'b00;
  localparam logic [1:0] IORD_EXC = 2'b01;
  localparam logic [1:0] IORD_ALU = 2'b10;
  localparam logic [1:0] IORD_RES = 2'b11;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {G_FETCH, G_DATA, G_EXC} grant_e;
  typedef enum logic {S_IDLE, S_ACCESS} state_e;

endpackage

// File: rtl/mem_port_sequencer_if.sv
// Request/acknowledge and memory-port control bundle between the CPU sources and the sequencer.
interface mem_port_sequencer_if;

  logic       fetch_req;
  logic       data_req;
  logic       data_we;
  logic       data_src;
  logic       exc_req;
  logic [1:0] iord_sel;
  logic       mem_wr;
  logic       ir_write;
  logic       mdr_write;
  logic       fetch_ack;
  logic       data_ack;
  logic       exc_ack;
  logic       busy;

  modport master (
    output fetch_req, data_req, data_we, data_src, exc_req,
    input  iord_sel, mem_wr, ir_write, mdr_write, fetch_ack, data_ack, exc_ack, busy
  );

  modport slave (
    input  fetch_req, data_req, data_we, data_src, exc_req,
    output iord_sel, mem_wr, ir_write, mdr_write, fetch_ack, data_ack, exc_ack, busy
  );

endinterface

// File: rtl/mem_port_sequencer_lat_counter.sv
// Memory-latency down counter: loads a start value, decrements to zero and holds there.
module lat_counter
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state is updated only with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_sequencer.sv
// Arbiter and access sequencer for the shared memory port; all outputs come from flops.
module mem_port_sequencer
  import ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT - 1);

  state_e     state_q, state_d;
  grant_e     grant_q, grant_d;
  logic [1:0] iord_sel_q, iord_sel_d;
  logic       we_q, we_d;
  logic       mem_wr_q, mem_wr_d;
  logic       ir_write_q, ir_write_d;
  logic       mdr_write_q, mdr_write_d;
  logic       fetch_ack_q, fetch_ack_d;
  logic       data_ack_q, data_ack_d;
  logic       exc_ack_q, exc_ack_d;

  logic             cnt_load, cnt_dec, cnt_zero, done_next;
  logic [CNT_W-1:0] cnt;

  lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_INIT),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    iord_sel_d  = iord_sel_q;
    we_d        = we_q;
    mem_wr_d    = 1'b0;
    ir_write_d  = 1'b0;
    mdr_write_d = 1'b0;
    fetch_ack_d = 1'b0;
    data_ack_d  = 1'b0;
    exc_ack_d   = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    done_next   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.exc_req || bus.data_req || bus.fetch_req) begin
          state_d  = S_ACCESS;
          cnt_load = 1'b1;
          if (bus.exc_req) begin
            grant_d    = G_EXC;
            iord_sel_d = IORD_EXC;
            we_d       = 1'b0;
          end else if (bus.data_req) begin
            grant_d    = G_DATA;
            iord_sel_d = bus.data_src ? IORD_RES : IORD_ALU;
            we_d       = bus.data_we;
          end else begin
            grant_d    = G_FETCH;
            iord_sel_d = IORD_PC;
            we_d       = 1'b0;
          end
          mem_wr_d  = (grant_d == G_DATA) && we_d;
          done_next = (LAT_INIT == '0);
        end
      end
      S_ACCESS: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
        end else begin
          cnt_dec   = 1'b1;
          done_next = (cnt == CNT_W'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered, so they are raised one edge before the final ACCESS cycle.
    if (done_next) begin
      unique case (grant_d)
        G_FETCH: begin ir_write_d = 1'b1; fetch_ack_d = 1'b1; end
        G_EXC:   begin ir_write_d = 1'b1; exc_ack_d   = 1'b1; end
        G_DATA:  begin mdr_write_d = !we_d; data_ack_d = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= G_FETCH;
      iord_sel_q  <= IORD_PC;
      we_q        <= 1'b0;
      mem_wr_q    <= 1'b0;
      ir_write_q  <= 1'b0;
      mdr_write_q <= 1'b0;
      fetch_ack_q <= 1'b0;
      data_ack_q  <= 1'b0;
      exc_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      iord_sel_q  <= iord_sel_d;
      we_q        <= we_d;
      mem_wr_q    <= mem_wr_d;
      ir_write_q  <= ir_write_d;
      mdr_write_q <= mdr_write_d;
      fetch_ack_q <= fetch_ack_d;
      data_ack_q  <= data_ack_d;
      exc_ack_q   <= exc_ack_d;
    end
  end

  assign bus.iord_sel  = iord_sel_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.ir_write  = ir_write_q;
  assign bus.mdr_write = mdr_write_q;
  assign bus.fetch_ack = fetch_ack_q;
  assign bus.data_ack  = data_ack_q;
  assign bus.exc_ack   = exc_ack_q;
  assign bus.busy      = (state_q == S_ACCESS);

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench: per-cycle vector table on a MEM_LAT=2 instance plus hand sequences for MEM_LAT=1 and async reset.
module tb_mem_port_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_port_sequencer_if if0 ();
  mem_port_sequencer_if if1 ();

  mem_port_sequencer #(.MEM_LAT(2)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  mem_port_sequencer #(.MEM_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  // exp bit order: {iord_sel[1:0], mem_wr, ir_write, mdr_write, fetch_ack, data_ack, exc_ack, busy}
  typedef struct packed {
    logic       rst;
    logic       f;
    logic       d;
    logic       we;
    logic       src;
    logic       e;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t v(input logic rst, f, d, we, src, e, input logic [8:0] exp);
    vec_t r;
    r.rst = rst; r.f = f; r.d = d; r.we = we; r.src = src; r.e = e; r.exp = exp;
    return r;
  endfunction

  function automatic logic [8:0] outs0();
    return {if0.iord_sel, if0.mem_wr, if0.ir_write, if0.mdr_write,
            if0.fetch_ack, if0.data_ack, if0.exc_ack, if0.busy};
  endfunction

  function automatic logic [8:0] outs1();
    return {if1.iord_sel, if1.mem_wr, if1.ir_write, if1.mdr_write,
            if1.fetch_ack, if1.data_ack, if1.exc_ack, if1.busy};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic drive1(input logic f, d, we, src, e);
    if1.fetch_req = f; if1.data_req = d; if1.data_we = we; if1.data_src = src; if1.exc_req = e;
  endtask

  initial begin
    if0.fetch_req = 1'b0; if0.data_req = 1'b0; if0.data_we = 1'b0;
    if0.data_src  = 1'b0; if0.exc_req  = 1'b0;
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    //               rst f d we src e   expected
    vecs[0]  = v(1, 0, 0, 0, 0, 0, 9'b00_0000000); // reset
    vecs[1]  = v(0, 0, 0, 0, 0, 0, 9'b00_0000000);
    vecs[2]  = v(0, 1, 0, 0, 0, 0, 9'b00_0000001); // fetch granted
    vecs[3]  = v(0, 1, 0, 0, 0, 0, 9'b00_0101001); // ir_write + fetch_ack
    vecs[4]  = v(0, 0, 0, 0, 0, 0, 9'b00_0000000);
    vecs[5]  = v(0, 0, 1, 1, 0, 0, 9'b10_1000001); // store via ALU_out, mem_wr
    vecs[6]  = v(0, 0, 1, 0, 1, 0, 9'b10_0000101); // late we/src change ignored
    vecs[7]  = v(0, 0, 0, 0, 0, 0, 9'b10_0000000); // iord_sel held in IDLE
    vecs[8]  = v(0, 1, 1, 0, 1, 1, 9'b01_0000001); // all three: EXC first
    vecs[9]  = v(0, 1, 1, 0, 1, 1, 9'b01_0100011);
    vecs[10] = v(0, 1, 1, 0, 1, 0, 9'b01_0000000);
    vecs[11] = v(0, 1, 1, 0, 1, 0, 9'b11_0000001); // then DATA load from result
    vecs[12] = v(0, 1, 1, 0, 1, 0, 9'b11_0010101);
    vecs[13] = v(0, 1, 0, 0, 0, 0, 9'b11_0000000);
    vecs[14] = v(0, 1, 0, 0, 0, 0, 9'b00_0000001); // then FETCH
    vecs[15] = v(0, 1, 0, 0, 0, 0, 9'b00_0101001);
    vecs[16] = v(0, 0, 0, 0, 0, 0, 9'b00_0000000);
    vecs[17] = v(0, 0, 1, 0, 1, 0, 9'b11_0000001); // load from result
    vecs[18] = v(0, 1, 1, 0, 1, 1, 9'b11_0010101); // exc mid-access: no preemption
    vecs[19] = v(0, 1, 0, 0, 0, 1, 9'b11_0000000);
    vecs[20] = v(0, 1, 0, 0, 0, 1, 9'b01_0000001); // exc ahead of fetch
    vecs[21] = v(0, 1, 0, 0, 0, 1, 9'b01_0100011);
    vecs[22] = v(0, 1, 0, 0, 0, 0, 9'b01_0000000);
    vecs[23] = v(0, 1, 0, 0, 0, 0, 9'b00_0000001);
    vecs[24] = v(0, 1, 0, 0, 0, 0, 9'b00_0101001);
    vecs[25] = v(0, 0, 0, 0, 0, 0, 9'b00_0000000);
    vecs[26] = v(0, 0, 1, 0, 0, 0, 9'b10_0000001); // load, ACCESS cycle 1
    vecs[27] = v(1, 0, 1, 0, 0, 0, 9'b00_0000000); // reset aborts it
    vecs[28] = v(0, 0, 0, 0, 0, 0, 9'b00_0000000); // no mdr_write / data_ack
    vecs[29] = v(0, 0, 0, 0, 0, 0, 9'b00_0000000);

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      reset         = vecs[i].rst;
      if0.fetch_req = vecs[i].f;
      if0.data_req  = vecs[i].d;
      if0.data_we   = vecs[i].we;
      if0.data_src  = vecs[i].src;
      if0.exc_req   = vecs[i].e;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), outs0(), vecs[i].exp);
    end

    // MEM_LAT=1: store then load
    @(negedge clk); drive1(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("lat1_store", outs1(), 9'b11_1000101);
    @(negedge clk); drive1(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("lat1_gap", outs1(), 9'b11_0000000);
    @(posedge clk); #1;
    check("lat1_load", outs1(), 9'b10_0010101);
    @(negedge clk); drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("lat1_idle", outs1(), 9'b10_0000000);

    // Async reset takes effect away from any clock edge
    @(negedge clk);
    if0.data_req = 1'b1; if0.data_we = 1'b0; if0.data_src = 1'b1;
    @(posedge clk); #1;
    check("arst_pre", outs0(), 9'b11_0000001);
    @(negedge clk); reset = 1'b1; #1;
    check("arst_now", outs0(), 9'b00_0000000);
    @(negedge clk); reset = 1'b0; if0.data_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("arst_after%0d", k), outs0(), 9'b00_0000000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_sequencer.md
# mem_port_sequencer

Sequencer and arbiter for the single shared memory port of the multicycle CPU. It accepts access requests from three sources: instruction fetch, data load/store and exception-vector read. It grants one request at a time and drives the 2-bit address-source select of the memory-address mux. It also produces the memory write strobe and the IR/MDR load strobes, timed to the memory read latency.

## Interface
Parameters:
- MEM_LAT, 2: cycles from address-valid to read-data-valid; legal range 1..7.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- fetch_req  in  1  instruction-fetch request, level, held until fetch_ack.
- data_req  in  1  data-access request, level, held until data_ack.
- data_we  in  1  1 = store, 0 = load; qualified by data_req.
- data_src  in  1  data address source: 0 = ALU_out, 1 = result.
- exc_req  in  1  exception-vector read request, level, held until exc_ack.
- iord_sel  out  2  mux select: 00 PC, 01 exception address, 10 ALU_out, 11 result.
- mem_wr  out  1  memory write enable.
- ir_write  out  1  load IR from memory data.
- mdr_write  out  1  load MDR from memory data.
- fetch_ack  out  1  one-cycle pulse.
- data_ack  out  1  one-cycle pulse.
- exc_ack  out  1  one-cycle pulse.
- busy  out  1  high while an access is in flight.

## Operation
- States:
  - IDLE: sample requests.
  - ACCESS: hold the grant and count latency.
- Arbitration in IDLE uses fixed priority exc_req > data_req > fetch_req. A lower-priority request waits while a higher one is pending.
- On grant, the following are latched and held constant for the whole access:
  - grant id (EXC/DATA/FETCH)
  - iord_sel: EXC→01, DATA→{1,data_src}, FETCH→00
  - data_we
- Counter cnt is loaded with MEM_LAT-1 on entry to ACCESS and decrements each ACCESS cycle. The access completes in the ACCESS cycle where cnt==0.
- On completion:
  - FETCH and EXC reads pulse ir_write. The exception vector is loaded into IR.
  - A DATA load pulses mdr_write.
  - A DATA store pulses no load strobe.
  - The matching *_ack pulses in the same cycle. The next state is IDLE.
- mem_wr is high only during the first ACCESS cycle of a DATA store.
- No preemption: exc_req raised mid-access is served at the next IDLE, ahead of any pending data or fetch request.
- A request deasserted before its ack is a protocol violation; the in-flight access completes regardless.
- data_we and data_src are sampled only at grant; later changes are ignored.
- In IDLE, iord_sel keeps its last value.
- Reset, including mid-access, forces IDLE and cnt=0. No strobe or ack is emitted for the aborted access.

## Timing
- Reset values:
  - iord_sel=00
  - all other outputs 0
- All outputs are registered or decoded from registered state only; there is no combinational path from the request inputs.
- Request high in the IDLE cycle at edge T, so ACCESS starts at T+1:
  - From T+1: busy=1 and iord_sel valid.
  - At T+1: mem_wr=1 for a store.
  - At T+MEM_LAT: strobe and ack.
  - At T+MEM_LAT+1: IDLE, busy=0.
- Back-to-back throughput is one access per MEM_LAT+1 cycles. The IDLE cycle after each ack is mandatory.
- With MEM_LAT=1, the single ACCESS cycle carries mem_wr (store) together with the strobe and ack.

## Structure
- Shared package ctrl_pkg holds:
  - IORD_PC=2'b00, IORD_EXC=2'b01, IORD_ALU=2'b10, IORD_RES=2'b11
  - grant enum {G_FETCH, G_DATA, G_EXC}
  - state enum {S_IDLE, S_ACCESS}
- The FSM and arbiter sit in one module.
- The latency counter is a natural sub-module, lat_counter. It loads MEM_LAT-1, decrements, and flags zero, with a 3-bit width.

## Test plan
- Reset, then fetch_req=1 with MEM_LAT=2: iord_sel=00 and busy=1 from cycle 1; ir_write and fetch_ack at cycle 2; busy=0 at cycle 3.
- data_req=1, data_we=1, data_src=0: iord_sel=10, mem_wr high only in ACCESS cycle 1, data_ack at cycle 2, no ir_write or mdr_write.
- fetch_req, data_req and exc_req all high simultaneously: service order EXC (iord_sel=01), then DATA, then FETCH; acks 3 cycles apart.
- exc_req raised during a load from result (iord_sel=11): the load completes with mdr_write, then exc is granted at the next IDLE ahead of a pending fetch.
- reset pulsed at ACCESS cycle 1 of a load: all outputs are 0 immediately, no mdr_write or data_ack, IDLE afterward.
- MEM_LAT=1 store then load: mem_wr and data_ack in the same cycle; IDLE gap; the load gives mdr_write one cycle after grant.
